if_fetch_unit: RTL and testbench

- Instruction-fetch initiator for the IF stage.
- Owns the program counter and drives the word address into the instruction memory, which returns a combinational 32-bit word.
- Captures each fetched word plus its next-PC into the IF/ID output register and hands it to decode with a valid/ready handshake.
- Handles stall, branch redirect/flush and halt-word detection.

---
 rtl/if_fetch_unit.sv | 99 +++++++++
 tb/tb_if_fetch_unit.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - instruction-fetch initiator for the IF stage
//
// Owns the program counter, drives the word address to a combinational
// instruction memory and captures each fetched word plus its next-PC into
// the IF/ID register, handed to decode with a valid/ready handshake.
// Handles stall, branch redirect/flush and halt-word detection.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        synchronous active-low reset
//   mem_addr     word address to instruction memory (zero-extended pc)
//   mem_data     instruction word for mem_addr, same cycle
//   redirect     branch/jump taken: flush IF/ID and reload pc
//   redirect_pc  new pc, low log2(DEPTH) bits used
//   out_valid    IF/ID holds a valid instruction
//   out_ready    decode accepts the instruction this cycle
//   out_instr    fetched instruction
//   out_npc      (fetch pc + 1) mod DEPTH, zero-extended
//   halted       fetch stopped on HALT_WORD
//   fetch_count  number of fetches performed, wraps at 2^32

module if_fetch_unit #(
  parameter int          DEPTH     = 128,
  parameter int          RESET_PC  = 0,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_data,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_npc,
  output logic        halted,
  output logic [31:0] fetch_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] RESET_PC_W = AW'(RESET_PC);

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  state_t        state;
  logic [AW-1:0] pc;
  logic [AW-1:0] pc_inc;
  logic          adv;
  logic          is_halt_word;

  // Only the low AW bits of the redirect target address the memory.
  logic unused_redirect_bits;
  assign unused_redirect_bits = ^redirect_pc[31:AW];

  // AW-bit addition wraps modulo DEPTH because DEPTH is a power of two.
  assign pc_inc       = pc + AW'(1);
  assign mem_addr     = {{(32-AW){1'b0}}, pc};
  assign is_halt_word = (mem_data == HALT_WORD);

  // The IF/ID slot can take a new word when empty or being drained.
  assign adv = (state == RUN) && (!out_valid || out_ready);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc          <= RESET_PC_W;
      out_valid   <= 1'b0;
      out_instr   <= 32'd0;
      out_npc     <= 32'd0;
      halted      <= 1'b0;
      fetch_count <= 32'd0;
      state       <= RUN;
    end else if (redirect) begin
      // Flush: whatever sits in IF/ID is dropped, even if accepted now.
      pc        <= redirect_pc[AW-1:0];
      out_valid <= 1'b0;
      state     <= RUN;
      halted    <= 1'b0;
    end else if (adv) begin
      out_instr   <= mem_data;
      out_npc     <= {{(32-AW){1'b0}}, pc_inc};
      out_valid   <= 1'b1;
      fetch_count <= fetch_count + 32'd1;
      if (is_halt_word) begin
        // pc stays on the halt word; the word itself is still presented.
        state  <= HALT;
        halted <= 1'b1;
      end else begin
        pc <= pc_inc;
      end
    end else if ((state == HALT) && out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - self-checking bench for if_fetch_unit

module tb_if_fetch_unit;

  localparam int          D  = 128;
  localparam logic [31:0] HW = 32'hFFFF_FFFF;

  logic        clk;
  logic        rst_n;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        out_ready;

  logic [31:0] mem_addr, mem_data, out_instr, out_npc, fetch_count;
  logic        out_valid, halted;

  logic [31:0] mem_addr2, mem_data2, out_instr2, out_npc2, fetch_count2;
  logic        out_valid2, halted2;

  logic [31:0] mem [0:D-1];

  int checks = 0;
  int errors = 0;

  assign mem_data  = mem[mem_addr[6:0]];
  assign mem_data2 = mem[mem_addr2[6:0]];

  if_fetch_unit #(.DEPTH(D), .RESET_PC(0), .HALT_WORD(HW)) u_dut (
    .clk(clk), .rst_n(rst_n), .mem_addr(mem_addr), .mem_data(mem_data),
    .redirect(redirect), .redirect_pc(redirect_pc), .out_valid(out_valid),
    .out_ready(out_ready), .out_instr(out_instr), .out_npc(out_npc),
    .halted(halted), .fetch_count(fetch_count)
  );

  if_fetch_unit #(.DEPTH(D), .RESET_PC(126), .HALT_WORD(HW)) u_dut_wrap (
    .clk(clk), .rst_n(rst_n), .mem_addr(mem_addr2), .mem_data(mem_data2),
    .redirect(redirect), .redirect_pc(redirect_pc), .out_valid(out_valid2),
    .out_ready(out_ready), .out_instr(out_instr2), .out_npc(out_npc2),
    .halted(halted2), .fetch_count(fetch_count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic init_mem();
    for (int i = 0; i < D; i++) mem[i] = 32'(i + 100);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; redirect = 1'b0; redirect_pc = 32'd0; out_ready = 1'b1;
    tick(); tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    checks++; if (out_instr !== 32'd0) begin errors++; $display("FAIL reset_instr: got %h expected 0", out_instr); end
    checks++; if (out_npc !== 32'd0) begin errors++; $display("FAIL reset_npc: got %h expected 0", out_npc); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b expected 0", halted); end
    checks++; if (fetch_count !== 32'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", fetch_count); end
    checks++; if (mem_addr !== 32'd0) begin errors++; $display("FAIL reset_addr: got %0d expected 0", mem_addr); end
    checks++; if (mem_addr2 !== 32'd126) begin errors++; $display("FAIL reset_addr_wrap: got %0d expected 126", mem_addr2); end
  endtask

  task automatic test_fetch();
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL fetch_valid[%0d]: got %b expected 1", i, out_valid); end
      checks++; if (out_instr !== 32'(100 + i)) begin errors++; $display("FAIL fetch_instr[%0d]: got %0d expected %0d", i, out_instr, 100 + i); end
      checks++; if (out_npc !== 32'(i + 1)) begin errors++; $display("FAIL fetch_npc[%0d]: got %0d expected %0d", i, out_npc, i + 1); end
    end
    checks++; if (fetch_count !== 32'd2) begin errors++; $display("FAIL fetch_count: got %0d expected 2", fetch_count); end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 4; i++) tick();
    checks++; if (out_instr !== 32'd105) begin errors++; $display("FAIL stall_pre_instr: got %0d expected 105", out_instr); end
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (out_instr !== 32'd105) begin errors++; $display("FAIL stall_instr[%0d]: got %0d expected 105", i, out_instr); end
      checks++; if (out_npc !== 32'd6) begin errors++; $display("FAIL stall_npc[%0d]: got %0d expected 6", i, out_npc); end
      checks++; if (mem_addr !== 32'd6) begin errors++; $display("FAIL stall_addr[%0d]: got %0d expected 6", i, mem_addr); end
      checks++; if (fetch_count !== 32'd6) begin errors++; $display("FAIL stall_count[%0d]: got %0d expected 6", i, fetch_count); end
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d]: got %b expected 1", i, out_valid); end
    end
    out_ready = 1'b1;
    tick();
    checks++; if (out_instr !== 32'd106) begin errors++; $display("FAIL stall_release: got %0d expected 106", out_instr); end
    checks++; if (fetch_count !== 32'd7) begin errors++; $display("FAIL stall_release_count: got %0d expected 7", fetch_count); end
  endtask

  task automatic test_redirect_stall();
    out_ready = 1'b0;
    tick();
    checks++; if (out_instr !== 32'd106 || out_valid !== 1'b1) begin errors++; $display("FAIL redir_pre: got %0d/%b expected 106/1", out_instr, out_valid); end
    redirect = 1'b1; redirect_pc = 32'd40;
    tick();
    redirect = 1'b0; out_ready = 1'b1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL redir_valid: got %b expected 0", out_valid); end
    checks++; if (mem_addr !== 32'd40) begin errors++; $display("FAIL redir_addr: got %0d expected 40", mem_addr); end
    checks++; if (out_instr !== 32'd106) begin errors++; $display("FAIL redir_hold_instr: got %0d expected 106", out_instr); end
    checks++; if (fetch_count !== 32'd7) begin errors++; $display("FAIL redir_count: got %0d expected 7", fetch_count); end
    tick();
    checks++; if (out_instr !== 32'd140) begin errors++; $display("FAIL redir_instr: got %0d expected 140", out_instr); end
    checks++; if (out_npc !== 32'd41) begin errors++; $display("FAIL redir_npc: got %0d expected 41", out_npc); end
  endtask

  task automatic test_wrap();
    int exp_pc [3];
    int exp_np [3];
    exp_pc = '{126, 127, 0};
    exp_np = '{127, 0, 1};
    rst_n = 1'b0; out_ready = 1'b1;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (out_instr2 !== 32'(exp_pc[i] + 100)) begin errors++; $display("FAIL wrap_instr[%0d]: got %0d expected %0d", i, out_instr2, exp_pc[i] + 100); end
      checks++; if (out_npc2 !== 32'(exp_np[i])) begin errors++; $display("FAIL wrap_npc[%0d]: got %0d expected %0d", i, out_npc2, exp_np[i]); end
      checks++; if (mem_addr2 !== 32'(exp_np[i])) begin errors++; $display("FAIL wrap_addr[%0d]: got %0d expected %0d", i, mem_addr2, exp_np[i]); end
    end
  endtask

  task automatic test_halt();
    mem[3] = HW;
    rst_n = 1'b0; out_ready = 1'b1;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    checks++; if (out_instr !== HW || out_valid !== 1'b1) begin errors++; $display("FAIL halt_word: got %h/%b expected %h/1", out_instr, out_valid, HW); end
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_flag: got %b expected 1", halted); end
    checks++; if (mem_addr !== 32'd3) begin errors++; $display("FAIL halt_addr: got %0d expected 3", mem_addr); end
    checks++; if (fetch_count !== 32'd4) begin errors++; $display("FAIL halt_count: got %0d expected 4", fetch_count); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL halt_drain_valid[%0d]: got %b expected 0", i, out_valid); end
      checks++; if (mem_addr !== 32'd3 || fetch_count !== 32'd4) begin errors++; $display("FAIL halt_frozen[%0d]: got %0d/%0d expected 3/4", i, mem_addr, fetch_count); end
    end
    redirect = 1'b1; redirect_pc = 32'd10;
    tick();
    redirect = 1'b0;
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL halt_clear: got %b expected 0", halted); end
    checks++; if (mem_addr !== 32'd10) begin errors++; $display("FAIL halt_redir_addr: got %0d expected 10", mem_addr); end
    tick();
    checks++; if (out_instr !== 32'd110 || out_npc !== 32'd11) begin errors++; $display("FAIL halt_resume: got %0d/%0d expected 110/11", out_instr, out_npc); end
    mem[3] = 32'd103;
  endtask

  task automatic test_reset_mid_stall();
    out_ready = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0 || out_instr !== 32'd0 || out_npc !== 32'd0 || halted !== 1'b0 || fetch_count !== 32'd0 || mem_addr !== 32'd0)
      begin errors++; $display("FAIL midreset_zero: got v=%b i=%h n=%h h=%b c=%0d a=%0d expected all 0", out_valid, out_instr, out_npc, halted, fetch_count, mem_addr); end
    rst_n = 1'b1; out_ready = 1'b1;
    tick();
    checks++; if (out_instr !== 32'd100 || fetch_count !== 32'd1) begin errors++; $display("FAIL midreset_restart: got %0d/%0d expected 100/1", out_instr, fetch_count); end
  endtask

  // Reference model: tracks the fetch PC and the contents of the IF/ID slot
  // as plain integers, advanced once per clock from the rules of the block.
  task automatic test_random();
    int  m_pc, m_npc, m_cnt;
    bit  m_valid, m_halt;
    logic [31:0] m_instr, w;
    for (int i = 0; i < D; i++)
      mem[i] = ($urandom_range(0, 19) == 0) ? HW : $urandom();
    rst_n = 1'b0; redirect = 1'b0; out_ready = 1'b1;
    tick();
    m_pc = 0; m_npc = 0; m_cnt = 0; m_valid = 0; m_halt = 0; m_instr = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      rst_n       = ($urandom_range(0, 63) != 0);
      redirect    = ($urandom_range(0, 15) == 0);
      redirect_pc = $urandom();
      out_ready   = ($urandom_range(0, 2) != 0);
      if (!rst_n) begin
        m_pc = 0; m_npc = 0; m_cnt = 0; m_valid = 0; m_halt = 0; m_instr = 0;
      end else if (redirect) begin
        m_pc = int'(redirect_pc % D); m_valid = 0; m_halt = 0;
      end else if (!m_halt && (!m_valid || out_ready)) begin
        w = mem[m_pc];
        m_instr = w; m_npc = (m_pc + 1) % D; m_valid = 1; m_cnt++;
        if (w == HW) m_halt = 1;
        else m_pc = (m_pc + 1) % D;
      end else if (m_halt && m_valid && out_ready) begin
        m_valid = 0;
      end
      tick();
      checks++;
      if (out_valid !== m_valid || out_instr !== m_instr || out_npc !== 32'(m_npc) ||
          halted !== m_halt || fetch_count !== 32'(m_cnt) || mem_addr !== 32'(m_pc)) begin
        errors++;
        $display("FAIL random[%0d]: got v=%b i=%h n=%0d h=%b c=%0d a=%0d expected v=%b i=%h n=%0d h=%b c=%0d a=%0d",
                 cyc, out_valid, out_instr, out_npc, halted, fetch_count, mem_addr,
                 m_valid, m_instr, m_npc, m_halt, m_cnt, m_pc);
      end
    end
  endtask

  initial begin
    init_mem();
    test_reset();
    test_fetch();
    test_stall();
    test_redirect_stall();
    test_wrap();
    test_halt();
    test_reset_mid_stall();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
